// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer.
// State encodings and the default step divider.
package cpu_seq_pkg;

    localparam logic [31:0] STEP_DIV_DEFAULT = 32'd20000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } seq_state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Step divider: one-clk tick every STEP_DIV clocks.
// Tick is masked while reset is held so no pulse leaks out.
module step_tick_gen #(
    parameter logic [31:0] STEP_DIV = 32'd20000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [31:0] cnt;
    logic        at_end;

    assign at_end = (cnt == STEP_DIV - 32'd1);
    assign tick   = at_end & ~reset;

    // Free-running divide counter, wraps to zero on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 32'd0;
        end else if (at_end) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALTED.
// State advances only on divider ticks; pulses coincide with that tick.
module cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] STEP_DIV = STEP_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cont,
    input  logic        halt,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_ready,
    output logic        fetch_req,
    output logic        ir_load,
    output logic        exec_en,
    output logic        data_req,
    output logic        wb_en,
    output logic        pc_en,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic        halt_pend_q;
    logic        halt_pend_d;
    logic [31:0] count_q;
    logic        tick;

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign fetch_req   = (state_q == S_FETCH);
    assign data_req    = (state_q == S_MEM);
    assign halted      = (state_q == S_HALTED);
    assign state       = state_q;
    assign instr_count = count_q;

    // Next-state and tick-aligned pulse decode
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        ir_load     = 1'b0;
        exec_en     = 1'b0;
        wb_en       = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (tick && mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (tick) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (tick) begin
                    exec_en = 1'b1;
                    if (halt) halt_pend_d = 1'b1;
                    if (mem_rd || mem_wr) state_d = S_MEM;
                    else                  state_d = S_WB;
                end
            end
            S_MEM: begin
                if (tick && mem_ready) state_d = S_WB;
            end
            S_WB: begin
                if (tick) begin
                    wb_en = 1'b1;
                    if (halt_pend_q) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                if (tick && cont) begin
                    pc_en       = 1'b1;
                    halt_pend_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and halt-pending registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Retired-instruction counter, bumps on the WB tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (tick && state_q == S_WB) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer.
// One instance at STEP_DIV=1, one at STEP_DIV=4, shared inputs.
module tb_cycle_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cont = 1'b0;
    logic halt = 1'b0;
    logic mem_rd = 1'b0;
    logic mem_wr = 1'b0;
    logic mem_ready = 1'b0;

    logic        a_fetch, a_irl, a_exe, a_dreq;
    logic        a_wb, a_pc, a_hlt;
    logic [2:0]  a_st;
    logic [31:0] a_cnt;

    logic        b_fetch, b_irl, b_exe, b_dreq;
    logic        b_wb, b_pc, b_hlt;
    logic [2:0]  b_st;
    logic [31:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cycle_sequencer #(.STEP_DIV(32'd1)) u1 (
        .clk(clk), .reset(reset), .cont(cont), .halt(halt),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .fetch_req(a_fetch), .ir_load(a_irl), .exec_en(a_exe),
        .data_req(a_dreq), .wb_en(a_wb), .pc_en(a_pc),
        .halted(a_hlt), .state(a_st), .instr_count(a_cnt)
    );

    cycle_sequencer #(.STEP_DIV(32'd4)) u4 (
        .clk(clk), .reset(reset), .cont(cont), .halt(halt),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .fetch_req(b_fetch), .ir_load(b_irl), .exec_en(b_exe),
        .data_req(b_dreq), .wb_en(b_wb), .pc_en(b_pc),
        .halted(b_hlt), .state(b_st), .instr_count(b_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (a_st !== 3'd0) begin
            errors++;
            $display("FAIL rst_state got %0d want 0", a_st);
        end
        checks++;
        if (a_fetch !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch got %b want 1", a_fetch);
        end
        checks++;
        if (a_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_cnt got %h want 0", a_cnt);
        end
        checks++;
        if ({a_irl, a_exe, a_wb, a_pc, a_dreq, a_hlt} !== 6'b0) begin
            errors++;
            $display("FAIL rst_pulses got %b want 000000",
                     {a_irl, a_exe, a_wb, a_pc, a_dreq, a_hlt});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        int npc = 0;
        mem_ready = 1'b1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        halt = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (a_st !== exp_st[i]) begin
                errors++;
                $display("FAIL alu_state[%0d] got %0d want %0d",
                         i, a_st, exp_st[i]);
            end
            if (a_pc) npc++;
            if (i == 0) begin
                checks++;
                if (a_irl !== 1'b1) begin
                    errors++;
                    $display("FAIL alu_irload got %b want 1", a_irl);
                end
            end
            if (i == 2) begin
                checks++;
                if (a_exe !== 1'b1) begin
                    errors++;
                    $display("FAIL alu_exec got %b want 1", a_exe);
                end
            end
            if (i == 3) begin
                checks++;
                if (a_wb !== 1'b1 || a_pc !== 1'b1) begin
                    errors++;
                    $display("FAIL alu_wb_pc got %b%b want 11",
                             a_wb, a_pc);
                end
            end
            if (i < 4) @(negedge clk);
        end
        checks++;
        if (a_cnt !== 32'd1) begin
            errors++;
            $display("FAIL alu_count got %0d want 1", a_cnt);
        end
        checks++;
        if (npc != 1) begin
            errors++;
            $display("FAIL alu_pc_count got %0d want 1", npc);
        end
    endtask

    task automatic test_load();
        int ndr = 0;
        int nwb = 0;
        mem_rd = 1'b1;
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            #1;
            if (a_dreq) ndr++;
            if (a_wb) nwb++;
            if (i == 7) begin
                checks++;
                if (a_st !== 3'd4) begin
                    errors++;
                    $display("FAIL load_wb_state got %0d want 4", a_st);
                end
            end
            if (i < 8) @(negedge clk);
        end
        checks++;
        if (ndr != 4) begin
            errors++;
            $display("FAIL load_data_req got %0d want 4", ndr);
        end
        checks++;
        if (nwb != 1) begin
            errors++;
            $display("FAIL load_wb_count got %0d want 1", nwb);
        end
        checks++;
        if (a_cnt !== 32'd1) begin
            errors++;
            $display("FAIL load_count got %0d want 1", a_cnt);
        end
        mem_rd = 1'b0;
    endtask

    task automatic test_halt();
        int npc = 0;
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            halt = (i == 2);
            cont = (i == 7);
            #1;
            if (i < 7 && a_pc) npc++;
            if (i == 5) begin
                checks++;
                if (a_st !== 3'd5 || a_hlt !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_state got %0d/%b want 5/1",
                             a_st, a_hlt);
                end
            end
            if (i == 7) begin
                checks++;
                if (a_pc !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_cont_pc got %b want 1", a_pc);
                end
            end
            if (i == 8) begin
                checks++;
                if (a_st !== 3'd0 || a_hlt !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_resume got %0d/%b want 0/0",
                             a_st, a_hlt);
                end
            end
            if (i < 8) @(negedge clk);
        end
        checks++;
        if (npc != 0) begin
            errors++;
            $display("FAIL halt_no_pc got %0d want 0", npc);
        end
        halt = 1'b0;
        cont = 1'b0;
    endtask

    task automatic test_tick4();
        int nir = 0;
        int nex = 0;
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            #1;
            if (b_irl) nir++;
            if (b_exe) nex++;
            if (i == 3) begin
                checks++;
                if (b_st !== 3'd0 || b_irl !== 1'b1) begin
                    errors++;
                    $display("FAIL t4_first_tick got %0d/%b want 0/1",
                             b_st, b_irl);
                end
            end
            if (i == 4) begin
                checks++;
                if (b_st !== 3'd1) begin
                    errors++;
                    $display("FAIL t4_decode got %0d want 1", b_st);
                end
            end
            if (i == 8) begin
                checks++;
                if (b_st !== 3'd2) begin
                    errors++;
                    $display("FAIL t4_exec got %0d want 2", b_st);
                end
            end
            if (i == 11) begin
                checks++;
                if (b_exe !== 1'b1) begin
                    errors++;
                    $display("FAIL t4_exec_pulse got %b want 1", b_exe);
                end
            end
            if (i == 12) begin
                checks++;
                if (b_st !== 3'd4) begin
                    errors++;
                    $display("FAIL t4_wb got %0d want 4", b_st);
                end
            end
            if (i < 12) @(negedge clk);
        end
        checks++;
        if (nir != 1 || nex != 1) begin
            errors++;
            $display("FAIL t4_pulse_counts got %0d/%0d want 1/1",
                     nir, nex);
        end
    endtask

    task automatic test_wrap();
        mem_ready = 1'b0;
        do_reset();
        force u1.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release u1.count_q;
        @(negedge clk);
        #1;
        checks++;
        if (a_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffffffff", a_cnt);
        end
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (a_cnt !== 32'd0 || a_st !== 3'd0) begin
            errors++;
            $display("FAIL wrap_count got %h/%0d want 0/0", a_cnt, a_st);
        end
    endtask

    task automatic test_reset_mid_mem();
        mem_rd = 1'b1;
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i < 2) ? 1'b1 : 1'b0;
            #1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (a_st !== 3'd3 || a_dreq !== 1'b1) begin
            errors++;
            $display("FAIL rmem_in_mem got %0d/%b want 3/1", a_st, a_dreq);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (a_st !== 3'd0 || a_dreq !== 1'b0 || a_fetch !== 1'b1) begin
            errors++;
            $display("FAIL rmem_async got %0d/%b/%b want 0/0/1",
                     a_st, a_dreq, a_fetch);
        end
        checks++;
        if (a_cnt !== 32'd0 || a_wb !== 1'b0) begin
            errors++;
            $display("FAIL rmem_outputs got %h/%b want 0/0", a_cnt, a_wb);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_halt();
        test_tick4();
        test_wrap();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
